// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store opcodes, load collector state encoding and
// register-file address width.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_LB  = 6'd32;
    localparam logic [5:0] OP_LH  = 6'd33;
    localparam logic [5:0] OP_LWL = 6'd34;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_LBU = 6'd36;
    localparam logic [5:0] OP_LHU = 6'd37;
    localparam logic [5:0] OP_LWR = 6'd38;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } collector_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: extracts, extends or merges a returned
// little-endian word according to the load opcode and address low bits.
module load_align
    import cpu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  ea,
    input  logic [31:0] rt_data,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        rf_wen
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[7:0];
        unique case (ea)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = ea[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data   = '0;
        rf_wen = 1'b1;
        case (opcode)
            OP_LB:  data = {{24{b[7]}}, b};
            OP_LBU: data = {24'd0, b};
            OP_LH:  data = {{16{h[15]}}, h};
            OP_LHU: data = {16'd0, h};
            OP_LW:  data = rdata;
            // lwl fills the word's upper bytes from memory, keeping rt's low bytes
            OP_LWL: begin
                unique case (ea)
                    2'd0: data = {rdata[7:0],  rt_data[23:0]};
                    2'd1: data = {rdata[15:0], rt_data[15:0]};
                    2'd2: data = {rdata[23:0], rt_data[7:0]};
                    2'd3: data = rdata;
                    default: data = rdata;
                endcase
            end
            OP_LWR: begin
                unique case (ea)
                    2'd0: data = rdata;
                    2'd1: data = {rt_data[31:24], rdata[31:8]};
                    2'd2: data = {rt_data[31:16], rdata[31:16]};
                    2'd3: data = {rt_data[31:8],  rdata[31:24]};
                    default: data = rdata;
                endcase
            end
            default: rf_wen = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_result_collector.sv
// Captures one load request, waits for the memory response, aligns it and holds
// the result for writeback under a valid/ready handshake; flush drops it safely.
module load_result_collector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [1:0]        req_ea,
    input  logic [DATA_W-1:0] req_rt_data,
    input  logic [REG_AW-1:0] req_dest,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_rf_wen,
    output logic              busy
);

    import cpu_pkg::*;

    collector_state_e  state_q, state_d;
    logic [5:0]        op_q;
    logic [1:0]        ea_q;
    logic [DATA_W-1:0] rt_q;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [REG_AW-1:0] wb_dest_q;
    logic              wb_rf_wen_q;

    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] align_data;
    logic              align_wen;

    load_align u_load_align (
        .opcode  (op_q),
        .ea      (ea_q),
        .rt_data (rt_q),
        .rdata   (mem_rdata),
        .data    (align_data),
        .rf_wen  (align_wen)
    );

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        req_ready = !flush && ((state_q == StIdle) || ((state_q == StHold) && wb_ready));
        accept    = req_valid && req_ready;
        unique case (state_q)
            StIdle: if (accept) state_d = StWait;
            StWait: begin
                if (flush) begin
                    // A response arriving with the flush is simply dropped
                    state_d = mem_rvalid ? StIdle : StDrain;
                end else if (mem_rvalid) begin
                    state_d = StHold;
                    capture = 1'b1;
                end
            end
            StHold: begin
                if (flush)         state_d = StIdle;
                else if (wb_ready) state_d = accept ? StWait : StIdle;
            end
            StDrain: if (mem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            ea_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            wb_data_q   <= '0;
            wb_dest_q   <= '0;
            wb_rf_wen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= req_opcode;
                ea_q   <= req_ea;
                rt_q   <= req_rt_data;
                dest_q <= req_dest;
            end
            if (capture) begin
                wb_data_q   <= align_data;
                wb_dest_q   <= dest_q;
                wb_rf_wen_q <= align_wen;
            end
        end
    end

    assign wb_valid  = (state_q == StHold);
    assign wb_data   = wb_data_q;
    assign wb_dest   = wb_dest_q;
    assign wb_rf_wen = wb_rf_wen_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_load_result_collector.sv
// Scoreboard bench for load_result_collector: directed loads, back-pressure,
// flush and reset scenarios with hand-computed expected results.
module tb_load_result_collector;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_opcode;
    logic [1:0]  req_ea;
    logic [31:0] req_rt_data;
    logic [4:0]  req_dest;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_rf_wen, busy;

    always #5 clk = ~clk;

    load_result_collector #(.DATA_W(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_ea      (req_ea),
        .req_rt_data (req_rt_data),
        .req_dest    (req_dest),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_dest     (wb_dest),
        .wb_rf_wen   (wb_rf_wen),
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        wen;
    } exp_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [1:0]  ea;
        logic [31:0] rt;
        logic [31:0] rd;
        logic [31:0] res;
        logic        wen;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each delivered result, and checks that a
    // stalled result does not change.
    logic        hold_seen = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_dest;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && hold_seen && wb_valid) begin
            check("wb_data_stable", wb_data, held_data);
            check("wb_dest_stable", {27'd0, wb_dest}, {27'd0, held_dest});
        end
        if (!rst && wb_valid && wb_ready && !flush) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_wb: got data 0x%08h, expected no result", wb_data);
            end else begin
                e = sb.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
                check("wb_rf_wen", {31'd0, wb_rf_wen}, {31'd0, e.wen});
            end
        end
        hold_seen = !rst && wb_valid && !wb_ready && !flush;
        held_data = wb_data;
        held_dest = wb_dest;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [1:0] ea, input logic [31:0] rt,
                         input logic [4:0] dest);
        req_valid   = 1'b1;
        req_opcode  = op;
        req_ea      = ea;
        req_rt_data = rt;
        req_dest    = dest;
        #1 check("req_ready_issue", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("wb_valid_in_wait", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic respond(input logic [31:0] rd, input logic [31:0] res, input logic [4:0] dest,
                           input logic wen);
        exp_t e;
        e.data = res;
        e.dest = dest;
        e.wen  = wen;
        sb.push_back(e);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        step();
        mem_rvalid = 1'b0;
        check("wb_valid_latency", {31'd0, wb_valid}, 32'd1);
    endtask

    task automatic retire();
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("idle_after_wb", {31'd0, busy}, 32'd0);
        check("wb_valid_dropped", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic run_load(input vec_t v, input logic [4:0] dest);
        issue(v.op, v.ea, v.rt, dest);
        step();
        check("wb_valid_before_resp", {31'd0, wb_valid}, 32'd0);
        respond(v.rd, v.res, dest, v.wen);
        retire();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_opcode = '0; req_ea = '0; req_rt_data = '0; req_dest = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0; wb_ready = 1'b0;

        vt.push_back('{OP_LB,  2'd3, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1});
        vt.push_back('{OP_LHU, 2'd2, 32'h0, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1});
        vt.push_back('{OP_LH,  2'd2, 32'h0, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b1});
        vt.push_back('{OP_LH,  2'd0, 32'h0, 32'hBEEF_1234, 32'h0000_1234, 1'b1});
        vt.push_back('{OP_LBU, 2'd0, 32'h0, 32'h1234_56F0, 32'h0000_00F0, 1'b1});
        vt.push_back('{OP_LB,  2'd0, 32'h0, 32'h1234_56F0, 32'hFFFF_FFF0, 1'b1});
        vt.push_back('{OP_LB,  2'd2, 32'h0, 32'h1234_56F0, 32'h0000_0034, 1'b1});
        vt.push_back('{OP_LW,  2'd0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1});
        vt.push_back('{OP_LWL, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344, 1'b1});
        vt.push_back('{OP_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344, 1'b1});
        vt.push_back('{OP_LWL, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'hBBCC_DD44, 1'b1});
        vt.push_back('{OP_LWL, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1});
        vt.push_back('{OP_LWR, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1});
        vt.push_back('{OP_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC, 1'b1});
        vt.push_back('{OP_LWR, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB, 1'b1});
        vt.push_back('{OP_LWR, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA, 1'b1});
        vt.push_back('{6'd43,  2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'h0000_0000, 1'b0});

        // Reset state
        #1;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rf_wen", {31'd0, wb_rf_wen}, 32'd0);
        step();
        rst = 1'b0;
        // Stray response in IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        check("idle_rvalid_ignored", {31'd0, busy}, 32'd0);

        foreach (vt[i]) run_load(vt[i], 5'(i + 1));

        // Back-to-back under back-pressure
        issue(OP_LW, 2'd0, 32'h0, 5'd3);
        step();
        respond(32'hCAFE_F00D, 32'hCAFE_F00D, 5'd3, 1'b1);
        req_valid = 1'b1; req_opcode = OP_LBU; req_ea = 2'd1; req_dest = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("req_ready_stalled", {31'd0, req_ready}, 32'd0);
            check("wb_data_held", wb_data, 32'hCAFE_F00D);
            step();
        end
        wb_ready = 1'b1;
        #1 check("req_ready_on_wb_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0; wb_ready = 1'b0;
        check("b2b_busy_wait", {31'd0, busy}, 32'd1);
        check("b2b_wb_valid_low", {31'd0, wb_valid}, 32'd0);
        respond(32'h0000_A500, 32'h0000_00A5, 5'd4, 1'b1);
        retire();

        // Flush in WAIT, response two cycles later
        issue(OP_LW, 2'd0, 32'h0, 5'd5);
        flush = 1'b1;
        #1 check("req_ready_flush", {31'd0, req_ready}, 32'd0);
        step();
        flush = 1'b0;
        check("drain_busy", {31'd0, busy}, 32'd1);
        req_valid = 1'b1; req_opcode = OP_LW; req_ea = 2'd0; req_dest = 5'd6;
        #1 check("drain_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1 check("drain_req_ready_resp", {31'd0, req_ready}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        check("drain_to_idle", {31'd0, busy}, 32'd0);
        check("drain_no_wb", {31'd0, wb_valid}, 32'd0);
        #1 check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("post_drain_accept", {31'd0, busy}, 32'd1);
        step();
        respond(32'h600D_600D, 32'h600D_600D, 5'd6, 1'b1);
        retire();

        // Flush coincident with response in WAIT
        issue(OP_LW, 2'd0, 32'h0, 5'd7);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD1_BAD1;
        step();
        flush = 1'b0; mem_rvalid = 1'b0;
        check("flush_resp_idle", {31'd0, busy}, 32'd0);
        check("flush_resp_no_wb", {31'd0, wb_valid}, 32'd0);

        // Flush in HOLD with wb_ready high
        issue(OP_LW, 2'd0, 32'h0, 5'd8);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD2_BAD2;
        step();
        mem_rvalid = 1'b0;
        check("hold_reached", {31'd0, wb_valid}, 32'd1);
        flush = 1'b1; wb_ready = 1'b1;
        step();
        flush = 1'b0; wb_ready = 1'b0;
        check("hold_flush_no_wb", {31'd0, wb_valid}, 32'd0);
        check("hold_flush_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-WAIT
        issue(OP_LB, 2'd1, 32'h0, 5'd9);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_wb_data", wb_data, 32'd0);
        check("arst_wb_dest", {27'd0, wb_dest}, 32'd0);
        check("arst_wb_rf_wen", {31'd0, wb_rf_wen}, 32'd0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD3_BAD3;
        step();
        mem_rvalid = 1'b0;
        check("late_rvalid_busy", {31'd0, busy}, 32'd0);
        check("late_rvalid_wb", {31'd0, wb_valid}, 32'd0);
        step();

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d pending results, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
